// File: rtl/ucsbece154b_icache_pkg.sv
// Shared instruction-cache geometry and FSM encoding, also used by the cache controller.
package ucsbece154b_icache_pkg;

  localparam int CACHE_NUM_SETS   = 8;
  localparam int CACHE_BLOCK_SIZE = 4;
  localparam int CACHE_NUM_WAYS   = 4;

  localparam int CACHE_BLOCK_BITS = $clog2(CACHE_BLOCK_SIZE);
  localparam int CACHE_SET_BITS   = $clog2(CACHE_NUM_SETS);
  localparam int CACHE_WAY_BITS   = $clog2(CACHE_NUM_WAYS);
  localparam int CACHE_TAG_BITS   = 32 - CACHE_SET_BITS - CACHE_BLOCK_BITS - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_WAIT = 2'd1,
    FILL      = 2'd2
  } icache_state_e;

endpackage

// File: rtl/ucsbece154b_icache_way_match.sv
// Parallel tag/valid compare across all ways of one set; returns hit flag, way and word.
module ucsbece154b_icache_way_match #(
  parameter int NUM_WAYS = 4,
  parameter int TAG_BITS = 25,
  parameter int WAY_BITS = 2
) (
  input  logic [NUM_WAYS-1:0]               valid_i,
  input  logic [NUM_WAYS-1:0][TAG_BITS-1:0] tag_i,
  input  logic [TAG_BITS-1:0]               lookup_tag_i,
  input  logic [NUM_WAYS-1:0][31:0]         word_i,
  output logic                              hit_o,
  output logic [WAY_BITS-1:0]               way_o,
  output logic [31:0]                       word_o
);

  logic [NUM_WAYS-1:0] match;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_cmp
    assign match[w] = valid_i[w] && (tag_i[w] == lookup_tag_i);
  end

  // A tag lives in at most one way, so priority order does not matter.
  always_comb begin
    hit_o  = 1'b0;
    way_o  = '0;
    word_o = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match[w]) begin
        hit_o  = 1'b1;
        way_o  = WAY_BITS'(w);
        word_o = word_i[w];
      end
    end
  end

endmodule

// File: rtl/ucsbece154b_icache.sv
// Set-associative instruction cache: zero-latency hits, critical-word-first fill with
// early restart, round-robin replacement preferring invalid ways.
module ucsbece154b_icache
  import ucsbece154b_icache_pkg::*;
#(
  parameter int NUM_SETS   = CACHE_NUM_SETS,
  parameter int BLOCK_SIZE = CACHE_BLOCK_SIZE,
  parameter int NUM_WAYS   = CACHE_NUM_WAYS
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        ReadEnableF_i,
  input  logic [31:0] PCF_i,
  output logic [31:0] InstrF_o,
  output logic        ReadyF_o,
  output logic        ReadRequest_o,
  output logic [31:0] ReadAddress_o,
  input  logic [31:0] Datain_i,
  input  logic        Dataready_i
);

  localparam int BB = $clog2(BLOCK_SIZE);
  localparam int SB = $clog2(NUM_SETS);
  localparam int WB = $clog2(NUM_WAYS);
  localparam int TB = 32 - SB - BB - 2;

  logic [NUM_WAYS-1:0]                         valid_q [NUM_SETS];
  logic [WB-1:0]                               rr_q    [NUM_SETS];
  logic [NUM_WAYS-1:0][TB-1:0]                 tag_q   [NUM_SETS];
  logic [NUM_WAYS-1:0][BLOCK_SIZE-1:0][31:0]   data_q  [NUM_SETS];

  icache_state_e state_q, state_d;
  logic [BB-1:0] beat_q, beat_d;
  logic [29:0]   addr_q, addr_d;
  logic [WB-1:0] victim_q, victim_d;
  logic          from_rr_q, from_rr_d;

  logic [TB-1:0] pc_tag, fill_tag;
  logic [SB-1:0] pc_set, fill_set;
  logic [BB-1:0] pc_off, crit_off, fill_off;

  assign pc_tag   = PCF_i[31 -: TB];
  assign pc_set   = PCF_i[BB+2 +: SB];
  assign pc_off   = PCF_i[2 +: BB];
  assign fill_tag = addr_q[29 -: TB];
  assign fill_set = addr_q[BB +: SB];
  assign crit_off = addr_q[BB-1:0];

  logic [NUM_WAYS-1:0][31:0] way_word;
  logic                      hit;
  logic [WB-1:0]             hit_way;
  logic [31:0]               hit_word;

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) way_word[w] = data_q[pc_set][w][pc_off];
  end

  ucsbece154b_icache_way_match #(
    .NUM_WAYS (NUM_WAYS),
    .TAG_BITS (TB),
    .WAY_BITS (WB)
  ) u_way_match (
    .valid_i      (valid_q[pc_set]),
    .tag_i        (tag_q[pc_set]),
    .lookup_tag_i (pc_tag),
    .word_i       (way_word),
    .hit_o        (hit),
    .way_o        (hit_way),
    .word_o       (hit_word)
  );

  logic unused_bits;
  assign unused_bits = ^{PCF_i[1:0], hit_way};

  logic          any_inv;
  logic [WB-1:0] inv_way;

  always_comb begin
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[pc_set][w]) begin
        any_inv = 1'b1;
        inv_way = WB'(w);
      end
    end
  end

  logic        ready, req, alloc, fill_we, fill_done;
  logic [31:0] instr;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    victim_d  = victim_q;
    from_rr_d = from_rr_q;
    ready     = 1'b0;
    instr     = '0;
    req       = 1'b0;
    alloc     = 1'b0;
    fill_we   = 1'b0;
    fill_done = 1'b0;
    fill_off  = crit_off;
    unique case (state_q)
      IDLE: begin
        if (ReadEnableF_i) begin
          if (hit) begin
            ready = 1'b1;
            instr = hit_word;
          end else begin
            req       = 1'b1;
            alloc     = 1'b1;
            addr_d    = PCF_i[31:2];
            victim_d  = any_inv ? inv_way : rr_q[pc_set];
            from_rr_d = !any_inv;
            state_d   = MISS_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        // Early restart: the critical word goes straight to fetch.
        if (Dataready_i) begin
          fill_we = 1'b1;
          ready   = 1'b1;
          instr   = Datain_i;
          beat_d  = BB'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (Dataready_i) begin
          fill_we  = 1'b1;
          // Remaining offsets ascend, stepping over the critical one.
          fill_off = ((beat_q - BB'(1)) < crit_off) ? (beat_q - BB'(1)) : beat_q;
          if (beat_q == BB'(BLOCK_SIZE - 1)) begin
            fill_done = 1'b1;
            beat_d    = '0;
            state_d   = IDLE;
          end else begin
            beat_d = beat_q + BB'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset_i) begin
      ready = 1'b0;
      instr = '0;
      req   = 1'b0;
    end
  end

  assign ReadyF_o      = ready;
  assign InstrF_o      = instr;
  assign ReadRequest_o = req;
  assign ReadAddress_o = reset_i ? 32'd0 : (req ? {PCF_i[31:2], 2'b00} : {addr_q, 2'b00});

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      victim_q  <= '0;
      from_rr_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      victim_q  <= victim_d;
      from_rr_q <= from_rr_d;
      if (alloc) valid_q[pc_set][victim_d] <= 1'b0;
      if (fill_done) begin
        valid_q[fill_set][victim_q] <= 1'b1;
        if (from_rr_q) rr_q[fill_set] <= rr_q[fill_set] + WB'(1);
      end
    end
  end

  // Tag/data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_we)   data_q[fill_set][victim_q][fill_off] <= Datain_i;
    if (fill_done) tag_q[fill_set][victim_q]            <= fill_tag;
  end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Directed self-checking bench for ucsbece154b_icache (default 8 sets, 4 words, 4 ways).
module tb_ucsbece154b_icache;

  logic        clk = 1'b0;
  logic        reset_i, ReadEnableF_i, Dataready_i;
  logic [31:0] PCF_i, Datain_i;
  logic [31:0] InstrF_o, ReadAddress_o;
  logic        ReadyF_o, ReadRequest_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ucsbece154b_icache dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .ReadEnableF_i (ReadEnableF_i),
    .PCF_i         (PCF_i),
    .InstrF_o      (InstrF_o),
    .ReadyF_o      (ReadyF_o),
    .ReadRequest_o (ReadRequest_o),
    .ReadAddress_o (ReadAddress_o),
    .Datain_i      (Datain_i),
    .Dataready_i   (Dataready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; Dataready_i = 1'b0;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  // Miss on a block base (critical offset 0), beats ascend; word o = k*16+o.
  task automatic fill_base(input logic [31:0] base, input int k);
    ReadEnableF_i = 1'b1; PCF_i = base; Dataready_i = 1'b0;
    #1 chk("alloc_req", 32'(ReadRequest_o), 32'd1);
    tick();
    for (int o = 0; o < 4; o++) begin
      Dataready_i = 1'b1; Datain_i = 32'(k * 16 + o);
      tick();
    end
    Dataready_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; ReadEnableF_i = 1'b1; PCF_i = 32'h08; Dataready_i = 1'b0; Datain_i = '0;
    tick();
    #1;
    chk("rst_ready", 32'(ReadyF_o), 32'd0);
    chk("rst_req",   32'(ReadRequest_o), 32'd0);
    chk("rst_addr",  ReadAddress_o, 32'd0);
    chk("rst_instr", InstrF_o, 32'd0);
    tick();
    reset_i = 1'b0;

    // Cold miss at 0x08, beats 2,0,1,3
    #1;
    chk("cold_req",   32'(ReadRequest_o), 32'd1);
    chk("cold_raddr", ReadAddress_o, 32'h08);
    chk("cold_ready", 32'(ReadyF_o), 32'd0);
    tick();
    PCF_i = 32'h44;
    #1;
    chk("wait_req",   32'(ReadRequest_o), 32'd0);
    chk("wait_raddr", ReadAddress_o, 32'h08);
    chk("wait_ready", 32'(ReadyF_o), 32'd0);
    tick();
    PCF_i = 32'h08; Dataready_i = 1'b1; Datain_i = 32'hA;
    #1;
    chk("early_ready", 32'(ReadyF_o), 32'd1);
    chk("early_instr", InstrF_o, 32'hA);
    tick();
    Datain_i = 32'h8;
    #1 chk("fill1_ready", 32'(ReadyF_o), 32'd0);
    tick();
    Datain_i = 32'hC;
    tick();
    Datain_i = 32'hE;
    #1 chk("fill3_ready", 32'(ReadyF_o), 32'd0);
    tick();
    Dataready_i = 1'b0; PCF_i = 32'h0C;
    #1;
    chk("hit0c_ready", 32'(ReadyF_o), 32'd1);
    chk("hit0c_instr", InstrF_o, 32'hE);
    chk("hit0c_req",   32'(ReadRequest_o), 32'd0);
    PCF_i = 32'h00; #1 chk("hit00_instr", InstrF_o, 32'h8);
    PCF_i = 32'h04; #1 chk("hit04_instr", InstrF_o, 32'hC);

    // Stray Dataready in IDLE must not write or signal ready
    tick();
    ReadEnableF_i = 1'b0; Dataready_i = 1'b1; Datain_i = 32'hDEAD;
    #1;
    chk("noren_ready", 32'(ReadyF_o), 32'd0);
    chk("noren_req",   32'(ReadRequest_o), 32'd0);
    tick();
    Dataready_i = 1'b0; ReadEnableF_i = 1'b1; PCF_i = 32'h08;
    #1 chk("stray_08", InstrF_o, 32'hA);
    PCF_i = 32'h0C; #1 chk("stray_0c", InstrF_o, 32'hE);

    // Critical offset 3 at 0x1C: beats 3,0,1,2
    tick();
    PCF_i = 32'h1C;
    #1 chk("crit3_raddr", ReadAddress_o, 32'h1C);
    tick();
    Dataready_i = 1'b1; Datain_i = 32'h13;
    #1 chk("crit3_early", InstrF_o, 32'h13);
    tick(); Datain_i = 32'h10;
    tick(); Datain_i = 32'h11;
    tick(); Datain_i = 32'h12;
    tick(); Dataready_i = 1'b0;
    PCF_i = 32'h10; #1 chk("crit3_w0", InstrF_o, 32'h10);
    PCF_i = 32'h14; #1 chk("crit3_w1", InstrF_o, 32'h11);
    PCF_i = 32'h18; #1 chk("crit3_w2", InstrF_o, 32'h12);
    PCF_i = 32'h1C; #1 chk("crit3_w3", InstrF_o, 32'h13);

    // Resident-line request during FILL stalls until the fill completes
    tick();
    PCF_i = 32'h24;
    #1 chk("busy_req", 32'(ReadRequest_o), 32'd1);
    tick();
    Dataready_i = 1'b1; Datain_i = 32'h21;
    #1 chk("busy_early", 32'(ReadyF_o), 32'd1);
    tick();
    PCF_i = 32'h0C; Datain_i = 32'h20;
    #1 chk("busy_b1_ready", 32'(ReadyF_o), 32'd0);
    tick(); Datain_i = 32'h22;
    #1 chk("busy_b2_ready", 32'(ReadyF_o), 32'd0);
    tick(); Datain_i = 32'h23;
    #1 chk("busy_b3_ready", 32'(ReadyF_o), 32'd0);
    tick(); Dataready_i = 1'b0;
    #1;
    chk("busy_after_ready", 32'(ReadyF_o), 32'd1);
    chk("busy_after_instr", InstrF_o, 32'hE);
    PCF_i = 32'h28; #1 chk("busy_new_w2", InstrF_o, 32'h22);
    PCF_i = 32'h20; #1 chk("busy_new_w0", InstrF_o, 32'h20);

    // Five tags into set 0: fifth evicts way 0
    do_reset();
    fill_base(32'h000, 1);
    fill_base(32'h080, 2);
    fill_base(32'h100, 3);
    fill_base(32'h180, 4);
    fill_base(32'h200, 5);
    PCF_i = 32'h204; #1 chk("rr_t5", InstrF_o, 32'h51);
    PCF_i = 32'h084; #1 chk("rr_t2", InstrF_o, 32'h21);
    PCF_i = 32'h108; #1 chk("rr_t3", InstrF_o, 32'h32);
    PCF_i = 32'h18C; #1 chk("rr_t4", InstrF_o, 32'h43);
    chk("rr_t4_ready", 32'(ReadyF_o), 32'd1);
    PCF_i = 32'h000;
    #1;
    chk("rr_t1_ready", 32'(ReadyF_o), 32'd0);
    chk("rr_t1_req",   32'(ReadRequest_o), 32'd1);

    // Reset after beat 1 abandons the fill
    do_reset();
    PCF_i = 32'h48;
    #1 chk("abort_req", 32'(ReadRequest_o), 32'd1);
    tick();
    Dataready_i = 1'b1; Datain_i = 32'h1;
    tick(); Datain_i = 32'h2;
    tick();
    reset_i = 1'b1; Dataready_i = 1'b0;
    #1;
    chk("abort_rst_ready", 32'(ReadyF_o), 32'd0);
    chk("abort_rst_addr",  ReadAddress_o, 32'd0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("abort_rereq",   32'(ReadRequest_o), 32'd1);
    chk("abort_readdr",  ReadAddress_o, 32'h48);
    chk("abort_reready", 32'(ReadyF_o), 32'd0);
    tick();
    Dataready_i = 1'b1; Datain_i = 32'h72;
    #1 chk("abort_early", InstrF_o, 32'h72);
    tick(); Datain_i = 32'h70;
    tick(); Datain_i = 32'h71;
    tick(); Datain_i = 32'h73;
    tick(); Dataready_i = 1'b0;
    PCF_i = 32'h40; #1 chk("abort_w0", InstrF_o, 32'h70);
    PCF_i = 32'h4C; #1 chk("abort_w3", InstrF_o, 32'h73);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
